// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback, allocation, operand-read and register-file write signals of the arbiter
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5
);
  logic wb0_valid;
  logic [REG_ADDR_W-1:0] wb0_rd;
  logic [XLEN-1:0] wb0_data;
  logic wb0_ready;
  logic wb1_valid;
  logic [REG_ADDR_W-1:0] wb1_rd;
  logic [XLEN-1:0] wb1_data;
  logic wb1_ready;
  logic alloc_valid;
  logic [REG_ADDR_W-1:0] alloc_rd;
  logic alloc_ready;
  logic rs1_enable;
  logic [REG_ADDR_W-1:0] rs1_sel;
  logic rs2_enable;
  logic [REG_ADDR_W-1:0] rs2_sel;
  logic hazard;
  logic busy;
  logic rd_enable;
  logic [REG_ADDR_W-1:0] rd_sel;
  logic [XLEN-1:0] rd_data;
  modport master (
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    output alloc_valid, alloc_rd, rs1_enable, rs1_sel, rs2_enable, rs2_sel,
    input wb0_ready, wb1_ready, alloc_ready, hazard, busy, rd_enable, rd_sel, rd_data
  );
  modport slave (
    input wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    input alloc_valid, alloc_rd, rs1_enable, rs1_sel, rs2_enable, rs2_sel,
    output wb0_ready, wb1_ready, alloc_ready, hazard, busy, rd_enable, rd_sel, rd_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port with a pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int N = 1 << REG_ADDR_W;
  logic [N-1:0] pending;
  logic [N-1:0] pending_next;
  logic last_grant;
  logic grant;
  logic accept;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  always_comb begin
    grant = (bus.wb0_valid && bus.wb1_valid) ? ~last_grant : bus.wb1_valid;
    bus.wb0_ready = bus.wb0_valid && !grant;
    bus.wb1_ready = bus.wb1_valid && grant;
    accept = bus.wb0_ready || bus.wb1_ready;
    sel_rd = grant ? bus.wb1_rd : bus.wb0_rd;
    sel_data = grant ? bus.wb1_data : bus.wb0_data;
    bus.alloc_ready = !(bus.alloc_rd != '0 && pending[bus.alloc_rd]);
    bus.hazard = (bus.rs1_enable && bus.rs1_sel != '0 && pending[bus.rs1_sel]) ||
                 (bus.rs2_enable && bus.rs2_sel != '0 && pending[bus.rs2_sel]);
    bus.busy = |pending;
  end
  // clear first so a same-cycle allocation of the same index wins
  always_comb begin
    pending_next = pending;
    if (bus.wb1_ready) pending_next[bus.wb1_rd] = 1'b0;
    if (bus.alloc_valid && bus.alloc_ready) pending_next[bus.alloc_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      last_grant <= 1'b1;
      bus.rd_enable <= 1'b0;
      bus.rd_sel <= '0;
      bus.rd_data <= '0;
    end else begin
      pending <= pending_next;
      bus.rd_enable <= accept && sel_rd != '0;
      if (accept) begin
        last_grant <= grant;
        bus.rd_sel <= sel_rd;
        bus.rd_data <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenario tasks for the writeback arbiter and scoreboard
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  regfile_wb_arbiter_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
  regfile_wb_arbiter #(.XLEN(32), .REG_ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle();
    bus.wb0_valid = 0; bus.wb0_rd = 0; bus.wb0_data = 0;
    bus.wb1_valid = 0; bus.wb1_rd = 0; bus.wb1_data = 0;
    bus.alloc_valid = 0; bus.alloc_rd = 0;
    bus.rs1_enable = 0; bus.rs1_sel = 0; bus.rs2_enable = 0; bus.rs2_sel = 0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #1;
    checks++; if (bus.rd_enable !== 1'b0) begin errors++; $display("FAIL reset_rd_enable got=%0b exp=0", bus.rd_enable); end
    checks++; if (bus.rd_sel !== 5'd0 || bus.rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_sel_data got=%0d/%h exp=0/0", bus.rd_sel, bus.rd_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++; if (bus.rd_enable !== 1'b0) begin errors++; $display("FAIL reset_no_write got=%0b exp=0", bus.rd_enable); end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bus.wb0_valid = 1; bus.wb0_rd = 5; bus.wb0_data = 32'h1234;
    #1;
    checks++; if (bus.wb0_ready !== 1'b1 || bus.wb1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got=%0b%0b exp=10", bus.wb0_ready, bus.wb1_ready); end
    @(posedge clk); #1;
    bus.wb0_valid = 0;
    checks++; if (bus.rd_enable !== 1'b1 || bus.rd_sel !== 5'd5 || bus.rd_data !== 32'h1234) begin errors++; $display("FAIL single_write got=%0b/%0d/%h exp=1/5/1234", bus.rd_enable, bus.rd_sel, bus.rd_data); end
    @(posedge clk); #1;
    checks++; if (bus.rd_enable !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b exp=0", bus.rd_enable); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.wb0_valid = 1; bus.wb0_rd = 1; bus.wb0_data = 32'hAAAA_0001;
    bus.wb1_valid = 1; bus.wb1_rd = 2; bus.wb1_data = 32'hBBBB_0002;
    #1;
    checks++; if (bus.wb0_ready !== 1'b1 || bus.wb1_ready !== 1'b0) begin errors++; $display("FAIL b2b_first_grant got=%0b%0b exp=10", bus.wb0_ready, bus.wb1_ready); end
    @(posedge clk); #1;
    bus.wb0_valid = 0;
    checks++; if (bus.rd_enable !== 1'b1 || bus.rd_sel !== 5'd1 || bus.rd_data !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_write0 got=%0b/%0d/%h exp=1/1/aaaa0001", bus.rd_enable, bus.rd_sel, bus.rd_data); end
    #1;
    checks++; if (bus.wb0_ready !== 1'b0 || bus.wb1_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_grant got=%0b%0b exp=01", bus.wb0_ready, bus.wb1_ready); end
    @(posedge clk); #1;
    bus.wb1_valid = 0;
    checks++; if (bus.rd_enable !== 1'b1 || bus.rd_sel !== 5'd2 || bus.rd_data !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_write1 got=%0b/%0d/%h exp=1/2/bbbb0002", bus.rd_enable, bus.rd_sel, bus.rd_data); end
    @(posedge clk); #1;
    checks++; if (bus.rd_enable !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%0b exp=0", bus.rd_enable); end
    @(negedge clk);
    bus.wb0_valid = 1; bus.wb1_valid = 1;
    #1;
    checks++; if (bus.wb0_ready !== 1'b1 || bus.wb1_ready !== 1'b0) begin errors++; $display("FAIL b2b_rr_after_wb1 got=%0b%0b exp=10", bus.wb0_ready, bus.wb1_ready); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    bus.alloc_valid = 1; bus.alloc_rd = 7;
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL sb_alloc_ready got=%0b exp=1", bus.alloc_ready); end
    @(posedge clk); #1;
    bus.alloc_valid = 0;
    bus.rs1_enable = 1; bus.rs1_sel = 7;
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.hazard !== 1'b1) begin errors++; $display("FAIL sb_pending got=busy%0b/hz%0b exp=1/1", bus.busy, bus.hazard); end
    bus.rs1_enable = 0; bus.rs2_enable = 1; bus.rs2_sel = 7;
    #1;
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_rs2 got=%0b exp=1", bus.hazard); end
    bus.rs2_enable = 0;
    #1;
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL sb_hazard_disabled got=%0b exp=0", bus.hazard); end
    bus.rs1_enable = 1;
    bus.alloc_valid = 1;
    #1;
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL sb_waw_stall got=%0b exp=0", bus.alloc_ready); end
    bus.alloc_valid = 0;
    @(negedge clk);
    bus.wb1_valid = 1; bus.wb1_rd = 7; bus.wb1_data = 32'hC0DE_0007;
    #1;
    checks++; if (bus.wb1_ready !== 1'b1 || bus.hazard !== 1'b1) begin errors++; $display("FAIL sb_wb1_accept got=rdy%0b/hz%0b exp=1/1", bus.wb1_ready, bus.hazard); end
    @(posedge clk); #1;
    bus.wb1_valid = 0;
    checks++; if (bus.hazard !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL sb_cleared got=hz%0b/busy%0b exp=0/0", bus.hazard, bus.busy); end
    checks++; if (bus.rd_enable !== 1'b1 || bus.rd_sel !== 5'd7 || bus.rd_data !== 32'hC0DE_0007) begin errors++; $display("FAIL sb_write got=%0b/%0d/%h exp=1/7/c0de0007", bus.rd_enable, bus.rd_sel, bus.rd_data); end
    idle();
  endtask

  task automatic test_set_clear_same_cycle();
    @(negedge clk);
    bus.alloc_valid = 1; bus.alloc_rd = 9;
    @(posedge clk); #1;
    bus.wb1_valid = 1; bus.wb1_rd = 9; bus.wb1_data = 32'h9;
    #1;
    checks++; if (bus.alloc_ready !== 1'b0 || bus.wb1_ready !== 1'b1) begin errors++; $display("FAIL sc_blocked got=alloc%0b/wb1%0b exp=0/1", bus.alloc_ready, bus.wb1_ready); end
    @(posedge clk); #1;
    idle();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sc_cleared got=%0b exp=0", bus.busy); end
    @(negedge clk);
    bus.alloc_valid = 1; bus.alloc_rd = 9;
    bus.wb1_valid = 1; bus.wb1_rd = 9; bus.wb1_data = 32'h99;
    #1;
    checks++; if (bus.alloc_ready !== 1'b1 || bus.wb1_ready !== 1'b1) begin errors++; $display("FAIL sc_both got=alloc%0b/wb1%0b exp=1/1", bus.alloc_ready, bus.wb1_ready); end
    @(posedge clk); #1;
    idle();
    bus.rs1_enable = 1; bus.rs1_sel = 9;
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.hazard !== 1'b1) begin errors++; $display("FAIL sc_set_wins got=busy%0b/hz%0b exp=1/1", bus.busy, bus.hazard); end
    @(negedge clk);
    bus.rs1_enable = 0;
    bus.wb1_valid = 1; bus.wb1_rd = 9;
    @(posedge clk); #1;
    idle();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sc_final_clear got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_reg_zero();
    @(negedge clk);
    bus.wb0_valid = 1; bus.wb0_rd = 0; bus.wb0_data = 32'hDEAD;
    #1;
    checks++; if (bus.wb0_ready !== 1'b1) begin errors++; $display("FAIL z_wb0_ready got=%0b exp=1", bus.wb0_ready); end
    @(posedge clk); #1;
    bus.wb0_valid = 0;
    checks++; if (bus.rd_enable !== 1'b0) begin errors++; $display("FAIL z_no_write got=%0b exp=0", bus.rd_enable); end
    @(negedge clk);
    bus.alloc_valid = 1; bus.alloc_rd = 0;
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL z_alloc_ready got=%0b exp=1", bus.alloc_ready); end
    @(posedge clk); #1;
    bus.alloc_valid = 0;
    bus.rs1_enable = 1; bus.rs1_sel = 0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.hazard !== 1'b0) begin errors++; $display("FAIL z_no_pending got=busy%0b/hz%0b exp=0/0", bus.busy, bus.hazard); end
    idle();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.alloc_valid = 1; bus.alloc_rd = 3;
    @(negedge clk);
    bus.alloc_rd = 4;
    @(negedge clk);
    bus.alloc_valid = 0;
    bus.wb0_valid = 1; bus.wb0_rd = 6; bus.wb0_data = 32'h6666;
    @(posedge clk); #1;
    bus.wb0_valid = 0;
    checks++; if (bus.rd_enable !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL ar_before got=en%0b/busy%0b exp=1/1", bus.rd_enable, bus.busy); end
    #1 rst_n = 0;
    #1;
    checks++; if (bus.rd_enable !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ar_immediate got=en%0b/busy%0b exp=0/0", bus.rd_enable, bus.busy); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++; if (bus.rd_enable !== 1'b0) begin errors++; $display("FAIL ar_no_write got=%0b exp=0", bus.rd_enable); end
    @(negedge clk);
    bus.wb0_valid = 1; bus.wb0_rd = 1; bus.wb1_valid = 1; bus.wb1_rd = 2;
    #1;
    checks++; if (bus.wb0_ready !== 1'b1 || bus.wb1_ready !== 1'b0) begin errors++; $display("FAIL ar_first_grant got=%0b%0b exp=10", bus.wb0_ready, bus.wb1_ready); end
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_scoreboard();
    test_set_clear_same_cycle();
    test_reg_zero();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (rd_enable/rd_sel/rd_data) between two writeback requesters.
  - Requester 0: the single-cycle execute pipeline.
  - Requester 1: the multi-cycle unit (load/divide).
- Keeps a pending-write scoreboard for destinations allocated to requester 1.
- Flags read-after-write hazards on rs1/rs2 so decode stalls until the value is written.
- Sits between the execute/writeback stages and the register file.

Parameters:
XLEN, 32, data width of writeback values
REG_ADDR_W, 5, register index width (2**REG_ADDR_W registers, index 0 hardwired zero)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
wb0_valid  input  1  requester 0 has a writeback beat
wb0_rd  input  REG_ADDR_W  requester 0 destination
wb0_data  input  XLEN  requester 0 value
wb0_ready  output  1  requester 0 beat accepted this cycle
wb1_valid  input  1  requester 1 has a writeback beat
wb1_rd  input  REG_ADDR_W  requester 1 destination
wb1_data  input  XLEN  requester 1 value
wb1_ready  output  1  requester 1 beat accepted this cycle
alloc_valid  input  1  decode issues an op to requester 1
alloc_rd  input  REG_ADDR_W  destination of that op
alloc_ready  output  1  allocation accepted
rs1_enable  input  1  decode reads rs1
rs1_sel  input  REG_ADDR_W  rs1 index
rs2_enable  input  1  decode reads rs2
rs2_sel  input  REG_ADDR_W  rs2 index
hazard  output  1  a read operand is pending; decode must stall
busy  output  1  any scoreboard bit set
rd_enable  output  1  register-file write enable
rd_sel  output  REG_ADDR_W  register-file write index
rd_data  output  XLEN  register-file write data

Behaviour:
- Reset, asynchronous, while rst_n low:
  - rd_enable=0, rd_sel=0, rd_data=0.
  - All pending bits cleared.
  - last_grant=1, so requester 0 wins the first contention.
  - Reset mid-operation drops any accepted-but-unwritten beat. No write occurs on the first edge after release.
- Arbitration, combinational, within the cycle:
  - Only wb0_valid: grant 0. Only wb1_valid: grant 1.
  - Both valid: grant the requester not equal to last_grant (round-robin).
  - wbN_ready = wbN_valid && grant==N. Never both high.
  - Requesters hold valid/rd/data stable until ready.
- last_grant updates to the granted index on each accepted beat. It holds when idle.
- Write output, registered, one-cycle latency:
  - A beat accepted at edge N drives rd_enable=1 with rd_sel/rd_data during cycle N+1.
  - rd_enable=0 in any cycle following no acceptance.
  - A beat with rd==0 is accepted (ready high) but produces rd_enable=0.
  - Back-to-back accepts yield rd_enable high on consecutive cycles.
- Scoreboard, one pending bit per register; bit 0 never set:
  - alloc_ready = !(alloc_rd!=0 && pending[alloc_rd]). WAW allocations stall.
  - alloc_valid && alloc_ready && alloc_rd!=0 sets pending[alloc_rd] at the edge.
  - An accepted wb1 beat clears pending[wb1_rd] at the edge.
  - Set and clear of the same index in one cycle: set wins (bit stays 1).
- Hazard, combinational from current pending bits:
  - hazard = (rs1_enable && rs1_sel!=0 && pending[rs1_sel]) || (rs2_enable && rs2_sel!=0 && pending[rs2_sel]).
  - The clear at acceptance edge N coincides with the write in cycle N+1. The register file's same-cycle read bypass supplies the new value, so hazard is already low in cycle N+1.
- busy = OR of all pending bits, combinational.
- Requester 0 writes never touch the scoreboard.

Test Plan:
1. Reset, then wb0_valid, rd=5, data=0x1234 → wb0_ready=1 same cycle; next cycle rd_enable=1, rd_sel=5, rd_data=0x1234; following cycle rd_enable=0.
2. Both valid continuously: wb0 rd=1 data=A, wb1 rd=2 data=B, each dropping valid after its accept → grants 0, then 1; rd_sel 1 then 2 on consecutive cycles; never both readies high.
3. alloc rd=7 → busy=1; rs1_sel=7, rs1_enable=1 → hazard=1; alloc rd=7 again → alloc_ready=0; wb1 rd=7 accepted → next cycle hazard=0, busy=0, rd_enable=1, rd_sel=7.
4. wb1 rd=9 accepted in the same cycle as alloc rd=9 (pending[9] already set, so alloc_ready=0 that cycle). Separately, with pending[9] clear, alloc 9 in the same cycle as a wb1 accept of 9 → pending[9]=1 afterwards (set wins).
5. wb0 rd=0 valid → wb0_ready=1, rd_enable stays 0; alloc rd=0 → alloc_ready=1, busy stays 0, hazard on rs1_sel=0 stays 0.
6. Pending bits 3 and 4 set, wb0 beat just accepted, rst_n pulsed low asynchronously → rd_enable=0 immediately, busy=0, no write after release; first contention afterwards grants requester 0.
